sakebi_ethernet_frame_tx: RTL

//  Ethernet II frame builder, the transmit counterpart of the frame receiver.

---
 rtl/sakebi_ethernet_frame_tx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sakebi_ethernet_frame_tx.sv
// Ethernet II frame builder: emits dst MAC, src MAC, EtherType, then the payload stream,
// zero-padding short payloads up to MIN_PAYLOAD bytes. Preamble/SFD/FCS are added downstream.
module sakebi_ethernet_frame_tx #(
    parameter int DATA_WIDTH      = 8,
    parameter int MAC_ADDR_WIDTH  = DATA_WIDTH * 6,
    parameter int ETHERTYPE_WIDTH = DATA_WIDTH * 2,
    parameter int MIN_PAYLOAD     = 46
) (
    input  logic                       i_axis_ACLK,
    input  logic                       i_axis_ARESETn,
    input  logic                       i_axis_TVALID,
    output logic                       o_axis_TREADY,
    input  logic [DATA_WIDTH-1:0]      i_axis_TDATA,
    input  logic                       i_axis_TLAST,
    output logic                       o_axis_TVALID,
    input  logic                       i_axis_TREADY,
    output logic [DATA_WIDTH-1:0]      o_axis_TDATA,
    output logic                       o_axis_TLAST,
    input  logic [MAC_ADDR_WIDTH-1:0]  i_dst_mac_addr,
    input  logic [MAC_ADDR_WIDTH-1:0]  i_src_mac_addr,
    input  logic [ETHERTYPE_WIDTH-1:0] i_ethertype,
    output logic                       o_busy
);

    localparam int             LP_MAC_LO = MAC_ADDR_WIDTH - DATA_WIDTH;
    localparam logic [16:0]    LP_MIN    = 17'(MIN_PAYLOAD);

    typedef enum logic [2:0] {
        IDLE,
        MAC_DST,
        MAC_SRC,
        ETHERTYPE,
        PAYLOAD,
        PAD,
        DONE
    } state_t;

    state_t                     r_state;
    logic [MAC_ADDR_WIDTH-1:0]  r_dst_mac;
    logic [MAC_ADDR_WIDTH-1:0]  r_src_mac;
    logic [ETHERTYPE_WIDTH-1:0] r_ethertype;
    logic [2:0]                 r_hdr_cnt;
    logic [15:0]                r_pay_cnt;
    logic                       r_valid;
    logic [DATA_WIDTH-1:0]      r_data;
    logic                       r_last;

    logic                       w_out_xfer;
    logic                       w_in_xfer;
    logic                       w_tready;
    logic [16:0]                w_pay_next;

    assign w_tready    = (r_state == PAYLOAD) && (!r_valid || i_axis_TREADY);
    assign w_out_xfer  = r_valid && i_axis_TREADY;
    assign w_in_xfer   = i_axis_TVALID && w_tready;
    assign w_pay_next  = {1'b0, r_pay_cnt} + 17'd1;

    assign o_axis_TREADY = w_tready;
    assign o_axis_TVALID = r_valid;
    assign o_axis_TDATA  = r_data;
    assign o_axis_TLAST  = r_last;
    assign o_busy        = (r_state != IDLE);

    // MAC fields are kept as left-justified shift registers; r_hdr_cnt counts bytes still to load.
    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            r_state     <= IDLE;
            r_dst_mac   <= '0;
            r_src_mac   <= '0;
            r_ethertype <= '0;
            r_hdr_cnt   <= '0;
            r_pay_cnt   <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_last      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_axis_TVALID) begin
                        r_data      <= i_dst_mac_addr[MAC_ADDR_WIDTH-1 -: DATA_WIDTH];
                        r_dst_mac   <= {i_dst_mac_addr[LP_MAC_LO-1:0], {DATA_WIDTH{1'b0}}};
                        r_src_mac   <= i_src_mac_addr;
                        r_ethertype <= i_ethertype;
                        r_hdr_cnt   <= 3'd5;
                        r_pay_cnt   <= '0;
                        r_valid     <= 1'b1;
                        r_last      <= 1'b0;
                        r_state     <= MAC_DST;
                    end
                end
                MAC_DST: begin
                    if (w_out_xfer) begin
                        if (r_hdr_cnt == 3'd0) begin
                            r_data    <= r_src_mac[MAC_ADDR_WIDTH-1 -: DATA_WIDTH];
                            r_src_mac <= {r_src_mac[LP_MAC_LO-1:0], {DATA_WIDTH{1'b0}}};
                            r_hdr_cnt <= 3'd5;
                            r_state   <= MAC_SRC;
                        end else begin
                            r_data    <= r_dst_mac[MAC_ADDR_WIDTH-1 -: DATA_WIDTH];
                            r_dst_mac <= {r_dst_mac[LP_MAC_LO-1:0], {DATA_WIDTH{1'b0}}};
                            r_hdr_cnt <= r_hdr_cnt - 3'd1;
                        end
                    end
                end
                MAC_SRC: begin
                    if (w_out_xfer) begin
                        if (r_hdr_cnt == 3'd0) begin
                            r_data    <= r_ethertype[ETHERTYPE_WIDTH-1 -: DATA_WIDTH];
                            r_hdr_cnt <= 3'd1;
                            r_state   <= ETHERTYPE;
                        end else begin
                            r_data    <= r_src_mac[MAC_ADDR_WIDTH-1 -: DATA_WIDTH];
                            r_src_mac <= {r_src_mac[LP_MAC_LO-1:0], {DATA_WIDTH{1'b0}}};
                            r_hdr_cnt <= r_hdr_cnt - 3'd1;
                        end
                    end
                end
                ETHERTYPE: begin
                    if (w_out_xfer) begin
                        if (r_hdr_cnt == 3'd0) begin
                            r_valid <= 1'b0;
                            r_state <= PAYLOAD;
                        end else begin
                            r_data    <= r_ethertype[DATA_WIDTH-1:0];
                            r_hdr_cnt <= r_hdr_cnt - 3'd1;
                        end
                    end
                end
                // An input transfer always implies the held byte is gone, so it may be overwritten.
                PAYLOAD: begin
                    if (w_in_xfer) begin
                        r_data  <= i_axis_TDATA;
                        r_valid <= 1'b1;
                        if (r_pay_cnt != 16'hFFFF) begin
                            r_pay_cnt <= w_pay_next[15:0];
                        end
                        if (i_axis_TLAST) begin
                            if (w_pay_next >= LP_MIN) begin
                                r_last  <= 1'b1;
                                r_state <= DONE;
                            end else begin
                                r_last  <= 1'b0;
                                r_state <= PAD;
                            end
                        end
                    end else if (w_out_xfer) begin
                        r_valid <= 1'b0;
                    end
                end
                PAD: begin
                    if (w_out_xfer) begin
                        r_data    <= '0;
                        r_pay_cnt <= w_pay_next[15:0];
                        if (w_pay_next >= LP_MIN) begin
                            r_last  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (w_out_xfer) begin
                        r_valid   <= 1'b0;
                        r_last    <= 1'b0;
                        r_pay_cnt <= '0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
